// File: rtl/address_table_pkg.sv
// Shared sizing, table entry layout, FSM encodings and selection helpers
// for the switch MAC learning table.
package address_table_pkg;

  localparam int NUM_PORTS   = 4;
  localparam int NUM_ENTRIES = NUM_PORTS * 4;
  localparam int MAX_HIT     = 16;
  localparam int HIT_W       = $clog2(MAX_HIT);
  localparam int MAC_W       = 48;
  localparam int PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  // I/G bit: set for multicast and broadcast addresses
  localparam int GROUP_BIT   = 40;

  typedef struct packed {
    logic              valid;
    logic [MAC_W-1:0]  mac;
    logic [PORT_W-1:0] port;
  } entry_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AGE    = 3'd1;
  localparam logic [2:0] ST_LOOKUP = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  // {found, index} of the lowest-index entry that is not valid
  function automatic logic [IDX_W:0] find_free(input logic [NUM_ENTRIES-1:0] valid);
    logic [IDX_W:0] r;
    r = '0;
    for (int e = NUM_ENTRIES-1; e >= 0; e--)
      if (!valid[e]) r = {1'b1, IDX_W'(e)};
    return r;
  endfunction

  // Index of the smallest hit count; strict compare keeps the lowest index on ties
  function automatic logic [IDX_W-1:0] find_min_hit(input logic [NUM_ENTRIES-1:0][HIT_W-1:0] hit);
    logic [IDX_W-1:0] idx;
    logic [HIT_W-1:0] m;
    idx = '0;
    m   = hit[0];
    for (int e = 1; e < NUM_ENTRIES; e++)
      if (hit[e] < m) begin
        m   = hit[e];
        idx = IDX_W'(e);
      end
    return idx;
  endfunction

  function automatic logic [HIT_W-1:0] hit_inc(input logic [HIT_W-1:0] h);
    return (h == HIT_W'(MAX_HIT-1)) ? h : h + HIT_W'(1);
  endfunction

  function automatic logic is_group(input logic [MAC_W-1:0] mac);
    return mac[GROUP_BIT];
  endfunction

endpackage

// File: rtl/address_table_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after the last
// winner. Grant is combinational; the pointer moves only on advance.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  // Scan from ptr+1 around to ptr, first hit wins
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  // Pointer remembers the last winner; reset to N-1 so port 0 goes first
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ptr <= IDX_W'(N-1);
    else if (advance && |req) ptr <= grant_idx;
  end

endmodule

// File: rtl/address_table_ctrl.sv
// MAC learning table sequencer: arbitrates ingress ports, learns source
// MACs, looks up destinations and ages entries on a periodic strobe.
module address_table_ctrl
  import address_table_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0][MAC_W-1:0] req_src_mac,
  input  logic [NUM_PORTS-1:0][MAC_W-1:0] req_dst_mac,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [PORT_W-1:0]               resp_req_port,
  output logic                            resp_hit,
  output logic [PORT_W-1:0]               resp_dst_port,
  output logic                            resp_flood,
  input  logic                            age_tick,
  output logic                            table_full
);

  logic [2:0]                            state;
  logic                                  age_pending;
  entry_t [NUM_ENTRIES-1:0]              tbl;
  logic [NUM_ENTRIES-1:0][HIT_W-1:0]     hit;
  logic [NUM_ENTRIES-1:0]                valid_vec;

  logic [PORT_W-1:0] cap_port;
  logic [MAC_W-1:0]  cap_src, cap_dst;
  logic              src_match, dst_match;
  logic [IDX_W-1:0]  src_idx, dst_idx;

  logic              src_m_c, dst_m_c;
  logic [IDX_W-1:0]  src_i_c, dst_i_c;
  logic [IDX_W:0]    free_sel;
  logic [IDX_W-1:0]  learn_idx;

  logic                 arb_adv;
  logic [NUM_PORTS-1:0] arb_grant;
  logic [PORT_W-1:0]    arb_idx;

  // Grants only from IDLE and only when no aging pass is waiting
  assign arb_adv   = (state == ST_IDLE) && !age_pending;
  assign req_ready = arb_adv ? arb_grant : '0;

  rr_arbiter #(.N(NUM_PORTS), .IDX_W(PORT_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (arb_adv),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_valid
    assign valid_vec[e] = tbl[e].valid;
  end

  assign table_full = &valid_vec;

  // Parallel CAM compare; scanning downward leaves the lowest match
  always_comb begin
    src_m_c = 1'b0;
    src_i_c = '0;
    dst_m_c = 1'b0;
    dst_i_c = '0;
    for (int e = NUM_ENTRIES-1; e >= 0; e--) begin
      if (valid_vec[e] && tbl[e].mac == cap_src) begin
        src_m_c = 1'b1;
        src_i_c = IDX_W'(e);
      end
      if (valid_vec[e] && tbl[e].mac == cap_dst) begin
        dst_m_c = 1'b1;
        dst_i_c = IDX_W'(e);
      end
    end
  end

  // Learn slot on a source miss: first free entry, else coldest entry
  assign free_sel  = find_free(valid_vec);
  assign learn_idx = free_sel[IDX_W] ? free_sel[IDX_W-1:0] : find_min_hit(hit);

  // Control FSM, request capture and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      age_pending   <= 1'b0;
      cap_port      <= '0;
      cap_src       <= '0;
      cap_dst       <= '0;
      src_match     <= 1'b0;
      dst_match     <= 1'b0;
      src_idx       <= '0;
      dst_idx       <= '0;
      resp_valid    <= 1'b0;
      resp_req_port <= '0;
      resp_hit      <= 1'b0;
      resp_dst_port <= '0;
      resp_flood    <= 1'b0;
    end else begin
      // A tick landing during the AGE cycle is kept for the next pass
      if (state == ST_AGE) age_pending <= age_tick;
      else                 age_pending <= age_pending | age_tick;

      case (state)
        ST_IDLE: begin
          if (age_pending) begin
            state <= ST_AGE;
          end else if (|req_valid) begin
            cap_port <= arb_idx;
            cap_src  <= req_src_mac[arb_idx];
            cap_dst  <= req_dst_mac[arb_idx];
            state    <= ST_LOOKUP;
          end
        end
        ST_AGE: state <= ST_IDLE;
        ST_LOOKUP: begin
          src_match <= src_m_c;
          src_idx   <= src_i_c;
          dst_match <= dst_m_c;
          dst_idx   <= dst_i_c;
          state     <= ST_UPDATE;
        end
        ST_UPDATE: begin
          // Table is still the lookup snapshot here; the learn lands at the edge
          resp_valid    <= 1'b1;
          resp_req_port <= cap_port;
          if (is_group(cap_dst) || !dst_match) begin
            resp_hit      <= 1'b0;
            resp_flood    <= 1'b1;
            resp_dst_port <= '0;
          end else begin
            resp_hit      <= 1'b1;
            resp_flood    <= 1'b0;
            resp_dst_port <= tbl[dst_idx].port;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Table storage: aging pass and source learning
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl <= '0;
      hit <= '0;
    end else if (state == ST_AGE) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (tbl[e].valid) begin
          if (hit[e] != '0) hit[e] <= hit[e] - HIT_W'(1);
          else              tbl[e].valid <= 1'b0;
        end
      end
    end else if (state == ST_UPDATE && !is_group(cap_src)) begin
      if (src_match) begin
        // Station move: re-home the entry to the requester
        tbl[src_idx].port <= cap_port;
        hit[src_idx]      <= hit_inc(hit[src_idx]);
      end else begin
        tbl[learn_idx].valid <= 1'b1;
        tbl[learn_idx].mac   <= cap_src;
        tbl[learn_idx].port  <= cap_port;
        hit[learn_idx]       <= HIT_W'(1);
      end
    end
  end

endmodule

// File: doc/address_table_ctrl.md
Name: address_table_ctrl

Overview:
- Sequencer and arbiter for the switch's MAC address learning table.
- Shares one table between NUM_PORTS ingress requesters using round-robin grants.
- For each granted frame it learns the source MAC and looks up the destination MAC, then returns a forwarding decision.
- Owns the table storage: valid bits, MAC/port entries and saturating hit counters. Also runs replacement and periodic aging.

Parameters:
- NUM_PORTS, from switch_pkg: number of requesting ports.
- NUM_ENTRIES, NUM_PORTS*4: table depth.
- MAX_HIT, 16: hit-counter range; counters saturate at MAX_HIT-1.
- MAC_W, 48: MAC address width.

Ports:
- clk  in  1  — single clock domain.
- rst  in  1  — asynchronous, active-high reset.
- req_valid  in  [NUM_PORTS]  — port p has a frame header pending.
- req_ready  out  [NUM_PORTS]  — one-hot grant; request accepted when valid&&ready.
- req_src_mac  in  [NUM_PORTS][MAC_W]  — source MAC per port.
- req_dst_mac  in  [NUM_PORTS][MAC_W]  — destination MAC per port.
- resp_valid  out  1  — decision available.
- resp_ready  in  1  — consumer accepts decision.
- resp_req_port  out  PORT_W  — index of the port that made the request.
- resp_hit  out  1  — destination found in table.
- resp_dst_port  out  PORT_W  — learned egress port; valid only when resp_hit=1.
- resp_flood  out  1  — forward to all ports except the requester.
- age_tick  in  1  — single-cycle aging strobe.
- table_full  out  1  — all entries valid.

PORT_W = $clog2(NUM_PORTS). HIT_W = $clog2(MAX_HIT).

Behaviour:
- Reset values:
  - All valid bits, hit counters, req_ready, resp_* outputs and table_full = 0.
  - FSM = IDLE; age_pending = 0.
  - Round-robin pointer = NUM_PORTS-1, so port 0 is granted first.
- FSM states: IDLE, AGE, LOOKUP, UPDATE, RESP.
- IDLE:
  - If age_pending=1, go to AGE. Aging has priority over requests.
  - Otherwise, if any req_valid is set, assert req_ready for one cycle to the first valid port strictly after the pointer (wrapping). Capture that port's src/dst MAC and index, update the pointer to it, and go to LOOKUP.
  - If no request, remain in IDLE.
- AGE (1 cycle):
  - Every valid entry with hit>0 decrements by 1.
  - Every valid entry with hit=0 is invalidated.
  - Clear age_pending and return to IDLE.
- age_tick sets age_pending in any state. A tick arriving while in AGE is retained for the next pass, not lost.
- LOOKUP (1 cycle): fully parallel compare of the captured src and dst MACs against all valid entries.
  - Register src_match/src_idx and dst_match/dst_idx.
  - If more than one entry matches, the lowest index wins.
- UPDATE (1 cycle), source learning:
  - If the src MAC is multicast/broadcast (bit 40 = 1), no learning.
  - If src matched: overwrite the entry's port with the requester port and increment hit, saturating at MAX_HIT-1.
  - If src missed: write to the lowest-index invalid entry. If none is invalid, evict the entry with the minimum hit count, lowest index on ties.
  - A newly written entry gets valid=1 and hit=1.
- UPDATE, forwarding decision:
  - Computed from the LOOKUP snapshot, i.e. the table before this update's learn.
  - Dst is broadcast/multicast, or dst missed: resp_hit=0, resp_flood=1.
  - Dst hit: resp_hit=1, resp_dst_port = entry port, resp_flood=0.
  - Then go to RESP.
- RESP:
  - resp_valid=1 with stable resp_* fields until resp_ready=1. On that cycle, go to IDLE and clear resp_valid.
  - No new grant is issued while in RESP.
- Latency: grant at cycle N, resp_valid at N+3 with resp_ready held high. Maximum throughput is one request per 4 cycles.
- Arbitration is fair: a continuously requesting port waits at most NUM_PORTS-1 grants.
- table_full is combinational AND of all valid bits.
- An asynchronous reset mid-transaction drops the in-flight request with no response and clears the entire table.

Decomposition:
- address_table_pkg holds:
  - NUM_ENTRIES, MAX_HIT, HIT_W and MAC_W.
  - The entry struct {valid, mac, port}.
  - The FSM state enum.
  - Functions for free-slot selection and minimum-hit selection. The free-slot function treats "free" as !valid.
- One sub-module is natural: rr_arbiter (parameter N; inputs req[N], advance; output one-hot grant plus index; owns the pointer). It is reusable by egress queues.

Test Plan:
- Learn then hit: port 2 sends src=00:11:22:33:44:55, dst=FF:FF:FF:FF:FF:FF → resp_flood=1, req_port=2. Port 0 then sends dst=00:11:22:33:44:55 → resp_hit=1, dst_port=2, response 3 cycles after the grant.
- Round robin: ports 0, 1 and 3 hold req_valid continuously → grants in order 0, 1, 3, 0, 1, 3. Hold resp_ready=0 for 5 cycles → resp fields stable and no grant issued.
- Station move and saturation: same src MAC from port 1 seen 20 times, then from port 3 → entry port=3, hit=15 (not wrapped), still one entry used.
- Replacement: fill NUM_ENTRIES distinct MACs → table_full=1. Give entry 5 hit=1 and all others hit≥2, then learn a new MAC → written to index 5.
- Aging: two age_ticks on entries with hit=1 → first tick sets hit=0, second invalidates. A subsequent lookup of that dst → resp_flood=1. An age_tick arriving during RESP runs before the next grant.
- Reset: assert rst in LOOKUP → resp_valid=0, table_full=0, and a prior learned MAC now misses.
